// File: rtl/traffic_pkg.sv
// Shared lamp codes and phase encoding for the N-road traffic sequencer.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2,
    FLASH  = 2'd3
  } phase_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase up-counter: synchronous clear, terminal count against a runtime duration.
module phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [TW-1:0] dur,
  output logic          done
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else                count <= count + 1'b1;
  end

  assign done = (count == dur - 1'b1);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-road round-robin signal sequencer with yellow/all-red clearance,
// latched pedestrian requests and a night flash mode entered only from all-red.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_ROADS  = 4,
  parameter int GREEN_T    = 6,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 1,
  parameter int FLASH_HALF = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flash_mode,
  input  logic [NUM_ROADS-1:0]         ped_req,
  output logic [3*NUM_ROADS-1:0]       lights,
  output logic [NUM_ROADS-1:0]         walk,
  output logic [$clog2(NUM_ROADS)-1:0] active_road,
  output logic                         in_flash
);

  localparam int AW   = $clog2(NUM_ROADS);
  localparam int MAXD = max4(GREEN_T, YELLOW_T, ALLRED_T, FLASH_HALF);
  localparam int TW   = $clog2(MAXD) + 1;

  phase_e               state, state_next;
  logic [AW-1:0]        road_q, road_inc;
  logic [NUM_ROADS-1:0] pend_q, pend_next;
  logic                 walk_en_q;
  logic                 blink_q;
  logic [TW-1:0]        dur;
  logic                 timer_done;
  logic                 timer_clear;
  logic                 enter_green;

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .dur   (dur),
    .done  (timer_done)
  );

  assign road_inc = (road_q == AW'(NUM_ROADS - 1)) ? '0 : road_q + 1'b1;

  always_comb begin
    state_next = state;
    dur        = TW'(ALLRED_T);
    case (state)
      GREEN: begin
        dur = TW'(GREEN_T);
        if (timer_done) state_next = YELLOW;
      end
      YELLOW: begin
        dur = TW'(YELLOW_T);
        if (timer_done) state_next = ALLRED;
      end
      ALLRED: begin
        dur = TW'(ALLRED_T);
        // Flash request is only honoured here, so a running green always clears first.
        if (timer_done) state_next = flash_mode ? FLASH : GREEN;
      end
      FLASH: begin
        dur = TW'(FLASH_HALF);
        if (!flash_mode) state_next = ALLRED;
      end
      default: state_next = ALLRED;
    endcase
  end

  assign enter_green = (state == ALLRED) && (state_next == GREEN);
  // In FLASH the timer wraps each half-period to pace the blink.
  assign timer_clear = (state_next != state) || ((state == FLASH) && timer_done);

  always_comb begin
    pend_next = pend_q | ped_req;
    if (enter_green) pend_next[road_inc] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ALLRED;
      road_q    <= AW'(NUM_ROADS - 1);
      pend_q    <= '0;
      walk_en_q <= 1'b0;
      blink_q   <= 1'b1;
    end else begin
      state  <= state_next;
      pend_q <= pend_next;
      if (enter_green) begin
        road_q    <= road_inc;
        walk_en_q <= pend_q[road_inc] | ped_req[road_inc];
      end
      if ((state != FLASH) && (state_next == FLASH))
        blink_q <= 1'b1;
      else if ((state == FLASH) && (state_next == FLASH) && timer_done)
        blink_q <= ~blink_q;
    end
  end

  always_comb begin
    lights = '0;
    walk   = '0;
    for (int r = 0; r < NUM_ROADS; r++) begin
      lights[3*r +: 3] = LIGHT_RED;
      case (state)
        GREEN:   if (road_q == AW'(r)) lights[3*r +: 3] = LIGHT_GREEN;
        YELLOW:  if (road_q == AW'(r)) lights[3*r +: 3] = LIGHT_YELLOW;
        FLASH:   lights[3*r +: 3] = blink_q ? LIGHT_YELLOW : LIGHT_DARK;
        default: lights[3*r +: 3] = LIGHT_RED;
      endcase
    end
    if ((state == GREEN) && walk_en_q) walk[road_q] = 1'b1;
  end

  assign active_road = road_q;
  assign in_flash    = (state == FLASH);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: phase-schedule reference model feeds an expected queue,
// a monitor pops one entry per cycle and compares all outputs.
module tb_traffic_phase_ctrl;

  localparam int N          = 4;
  localparam int GREEN_T    = 6;
  localparam int YELLOW_T   = 2;
  localparam int ALLRED_T   = 1;
  localparam int FLASH_HALF = 4;
  localparam int AW         = $clog2(N);
  localparam int EW         = 3*N + N + AW + 1;

  localparam int P_GREEN  = 0;
  localparam int P_YELLOW = 1;
  localparam int P_ALLRED = 2;
  localparam int P_FLASH  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic flash_mode;
  logic [N-1:0] ped_req;
  logic [3*N-1:0] lights;
  logic [N-1:0] walk;
  logic [AW-1:0] active_road;
  logic in_flash;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_ROADS(N), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flash_mode  (flash_mode),
    .ped_req     (ped_req),
    .lights      (lights),
    .walk        (walk),
    .active_road (active_road),
    .in_flash    (in_flash)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: current phase, cycles left in it, road owning green
  int m_ph;
  int m_left;
  int m_road;
  logic [N-1:0] m_pend;
  bit m_walk_ok;
  bit m_blink;

  task automatic model_reset();
    m_ph      = P_ALLRED;
    m_left    = ALLRED_T;
    m_road    = N - 1;
    m_pend    = '0;
    m_walk_ok = 1'b0;
    m_blink   = 1'b1;
  endtask

  function automatic logic [EW-1:0] model_outputs();
    logic [3*N-1:0] l;
    logic [N-1:0] w;
    l = '0;
    w = '0;
    for (int r = 0; r < N; r++) begin
      if (m_ph == P_FLASH)                     l[3*r +: 3] = m_blink ? 3'b010 : 3'b000;
      else if (m_ph == P_GREEN && r == m_road)  l[3*r +: 3] = 3'b001;
      else if (m_ph == P_YELLOW && r == m_road) l[3*r +: 3] = 3'b010;
      else                                      l[3*r +: 3] = 3'b100;
    end
    if (m_ph == P_GREEN && m_walk_ok) w[m_road] = 1'b1;
    return {l, w, AW'(m_road), (m_ph == P_FLASH)};
  endfunction

  task automatic model_step(input bit rst, input bit fm, input logic [N-1:0] req);
    logic [N-1:0] np;
    if (rst) begin
      model_reset();
      return;
    end
    np = m_pend | req;
    case (m_ph)
      P_GREEN: begin
        m_left--;
        if (m_left == 0) begin m_ph = P_YELLOW; m_left = YELLOW_T; end
      end
      P_YELLOW: begin
        m_left--;
        if (m_left == 0) begin m_ph = P_ALLRED; m_left = ALLRED_T; end
      end
      P_ALLRED: begin
        m_left--;
        if (m_left == 0) begin
          if (fm) begin
            m_ph = P_FLASH; m_left = FLASH_HALF; m_blink = 1'b1;
          end else begin
            m_road    = (m_road + 1) % N;
            m_walk_ok = np[m_road];
            np[m_road] = 1'b0;
            m_ph = P_GREEN; m_left = GREEN_T;
          end
        end
      end
      default: begin
        if (!fm) begin
          m_ph = P_ALLRED; m_left = ALLRED_T;
        end else begin
          m_left--;
          if (m_left == 0) begin m_blink = !m_blink; m_left = FLASH_HALF; end
        end
      end
    endcase
    m_pend = np;
  endtask

  // driver: one cycle of stimulus, expected outputs for the state now visible
  task automatic drive(input bit rst, input bit fm, input logic [N-1:0] req);
    @(negedge clk);
    reset      = rst;
    flash_mode = fm;
    ped_req    = req;
    exp_q.push_back(model_outputs());
    model_step(rst, fm, req);
  endtask

  task automatic fail_bound(input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired, got no match, required the target phase", what);
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    int non_red;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (lights !== e[EW-1 -: 3*N]) begin
          miscompares++;
          $display("FAIL lights @%0t: got %b required %b", $time, lights, e[EW-1 -: 3*N]);
        end
        vectors++;
        if (walk !== e[N+AW : AW+1]) begin
          miscompares++;
          $display("FAIL walk @%0t: got %b required %b", $time, walk, e[N+AW : AW+1]);
        end
        vectors++;
        if (active_road !== e[AW:1]) begin
          miscompares++;
          $display("FAIL active_road @%0t: got %0d required %0d", $time, active_road, e[AW:1]);
        end
        vectors++;
        if (in_flash !== e[0]) begin
          miscompares++;
          $display("FAIL in_flash @%0t: got %b required %b", $time, in_flash, e[0]);
        end
        if (!in_flash) begin
          non_red = 0;
          for (int r = 0; r < N; r++) if (lights[3*r +: 3] !== 3'b100) non_red++;
          vectors++;
          if (non_red > 1) begin
            miscompares++;
            $display("FAIL safety @%0t: got %0d roads non-red required at most 1", $time, non_red);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [N-1:0] req;
    bit fm;
    bit rst;
    bit hit;
    reset      = 1'b1;
    flash_mode = 1'b0;
    ped_req    = '0;
    @(posedge clk);
    model_reset();
    repeat (2) drive(1'b1, 1'b0, '0);

    // four rounds with pedestrian pulses: road2 during road0 green, road1 during road1 green
    for (int c = 0; c < 150; c++) begin
      req = '0;
      if (c == 3)  req[2] = 1'b1;
      if (c == 12) req[1] = 1'b1;
      drive(1'b0, 1'b0, req);
    end

    // flash raised mid road0 green, held, then dropped
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (m_ph == P_GREEN && m_road == 0 && m_left == 3) hit = 1'b1;
      else drive(1'b0, 1'b0, '0);
    end
    if (!hit) fail_bound("flash_setup");
    repeat (30) drive(1'b0, 1'b1, '0);
    repeat (20) drive(1'b0, 1'b0, '0);

    // reset on the last yellow cycle of road2, with a request pending
    drive(1'b0, 1'b0, 4'b1000);
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (m_ph == P_YELLOW && m_road == 2 && m_left == 1) hit = 1'b1;
      else drive(1'b0, 1'b0, '0);
    end
    if (!hit) fail_bound("reset_setup");
    drive(1'b1, 1'b0, '0);
    repeat (40) drive(1'b0, 1'b0, '0);

    // randomized traffic
    fm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) fm = !fm;
      req = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      rst = ($urandom_range(0, 399) == 0);
      drive(rst, fm, req);
    end
    drive(1'b0, 1'b0, '0);

    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) fail_bound("drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
